// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the display scan controller.
// The state encoding, the anode-off level and the digit-index width live here.
package seg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   // Index width, never below 1 so a 2-digit build still has a real bus.
   function automatic int idx_w(input int num_digits);
      return (num_digits <= 2) ? 1 : $clog2(num_digits);
   endfunction

   function automatic logic an_off_lvl(input int active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter for the scan controller: counts cycles within a guard or show phase.
// The parent restarts it on every phase change and on disable.
module seg_scan_timer
   import seg_scan_ctrl_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_guard_end,
   output logic o_show_end
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign o_guard_end = (cnt == CNT_W'(GUARD_CYCLES - 1));
   assign o_show_end  = (cnt == CNT_W'(DIGIT_CYCLES - GUARD_CYCLES - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scan with guard intervals and frame-aligned double buffering.
// Every output is a register; next values are formed from the post-commit bank.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int CODE_W        = 2,
   parameter int DIGIT_CYCLES  = 50000,
   parameter int GUARD_CYCLES  = 500,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic                           i_load,
   input  logic [NUM_DIGITS*CODE_W-1:0]   i_codes,
   input  logic [NUM_DIGITS-1:0]          i_blank,
   output logic [CODE_W-1:0]              o_code,
   output logic [NUM_DIGITS-1:0]          o_an,
   output logic [idx_w(NUM_DIGITS)-1:0]   o_digit_idx,
   output logic                           o_frame_tick,
   output logic                           o_load_ack
);

   localparam int                  IW     = idx_w(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{an_off_lvl(AN_ACTIVE_LOW)}};

   scan_state_t                    state;
   logic [IW-1:0]                  idx, nxt_idx;
   logic [NUM_DIGITS*CODE_W-1:0]   stg_codes, act_codes, nxt_codes;
   logic [NUM_DIGITS-1:0]          stg_blank, act_blank, nxt_blank, sel_mask;
   logic                           pending, guard_end, show_end, restart;
   logic                           last_digit, wrap, commit;

   seg_scan_timer #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_timer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_restart   (restart),
      .o_guard_end (guard_end),
      .o_show_end  (show_end)
   );

   assign last_digit = (idx == IW'(NUM_DIGITS - 1));
   assign nxt_idx    = last_digit ? '0 : idx + 1'b1;
   assign wrap       = i_en && (state == ST_SHOW) && show_end && last_digit;
   assign commit     = pending && ((state == ST_IDLE) || wrap);
   // Outputs launched on the commit edge must already see the new bank.
   assign nxt_codes  = commit ? stg_codes : act_codes;
   assign nxt_blank  = commit ? stg_blank : act_blank;
   assign sel_mask   = nxt_blank[idx] ? '0 : (NUM_DIGITS'(1) << idx);

   always_comb begin
      restart = 1'b1;
      case (state)
         ST_GUARD: restart = guard_end || !i_en;
         ST_SHOW:  restart = show_end  || !i_en;
         default:  restart = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         pending      <= 1'b0;
         stg_codes    <= '0;
         act_codes    <= '0;
         stg_blank    <= '1;
         act_blank    <= '1;
         o_an         <= AN_OFF;
         o_code       <= '0;
         o_frame_tick <= 1'b0;
         o_load_ack   <= 1'b0;
      end else begin
         o_frame_tick <= 1'b0;
         o_load_ack   <= commit;
         if (commit) begin
            act_codes <= stg_codes;
            act_blank <= stg_blank;
         end
         if (i_load) begin
            stg_codes <= i_codes;
            stg_blank <= i_blank;
            pending   <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               idx    <= '0;
               o_an   <= AN_OFF;
               o_code <= '0;
               if (i_en) begin
                  state  <= ST_GUARD;
                  o_code <= nxt_codes[CODE_W-1:0];
               end
            end
            ST_GUARD: begin
               if (!i_en) begin
                  state  <= ST_IDLE;
                  idx    <= '0;
                  o_an   <= AN_OFF;
                  o_code <= '0;
               end else if (guard_end) begin
                  state <= ST_SHOW;
                  o_an  <= AN_OFF ^ sel_mask;
               end
            end
            ST_SHOW: begin
               if (!i_en) begin
                  state  <= ST_IDLE;
                  idx    <= '0;
                  o_an   <= AN_OFF;
                  o_code <= '0;
               end else if (show_end) begin
                  state        <= ST_GUARD;
                  idx          <= nxt_idx;
                  o_an         <= AN_OFF;
                  o_code       <= nxt_codes[nxt_idx*CODE_W +: CODE_W];
                  o_frame_tick <= last_digit;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
               o_an  <= AN_OFF;
            end
         endcase
      end
   end

   assign o_digit_idx = idx;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected snapshots and pulse cycles,
// a negedge monitor pops and compares them against the DUT.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       i_rst, i_en, i_load;
   logic [7:0] i_codes;
   logic [3:0] i_blank;
   logic [1:0] o_code;
   logic [3:0] o_an;
   logic [1:0] o_digit_idx;
   logic       o_frame_tick, o_load_ack;

   seg_scan_ctrl #(
      .NUM_DIGITS    (4),
      .CODE_W        (2),
      .DIGIT_CYCLES  (10),
      .GUARD_CYCLES  (2),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_en         (i_en),
      .i_load       (i_load),
      .i_codes      (i_codes),
      .i_blank      (i_blank),
      .o_code       (o_code),
      .o_an         (o_an),
      .o_digit_idx  (o_digit_idx),
      .o_frame_tick (o_frame_tick),
      .o_load_ack   (o_load_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [1:0] code;
      logic [1:0] idx;
      bit         pchk;
   } snap_t;

   snap_t sq[$];
   int    tick_q[$];
   int    ack_q[$];
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   bit    done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_snap(input int c, input logic [3:0] an, input logic [1:0] code,
                            input logic [1:0] idx, input bit pchk);
      snap_t s;
      s.cyc = c; s.an = an; s.code = code; s.idx = idx; s.pchk = pchk;
      sq.push_back(s);
   endtask

   // Expected outputs for n cycles of a frame starting at its first guard cycle.
   task automatic push_frame(input int base, input logic [7:0] codes, input logic [3:0] blank,
                             input int n);
      for (int o = 0; o < n; o++) begin
         int d, w;
         logic [3:0] an;
         d  = o / 10;
         w  = o % 10;
         an = 4'b1111;
         if (w >= 2 && !blank[d]) an[d] = 1'b0;
         push_snap(base + o, an, codes[d*2 +: 2], 2'(d), 1'b0);
      end
   endtask

   always @(negedge clk) begin
      for (int i = sq.size() - 1; i >= 0; i--) begin
         if (sq[i].cyc == cyc) begin
            total++;
            if (o_an !== sq[i].an || o_code !== sq[i].code || o_digit_idx !== sq[i].idx) begin
               bad++;
               $display("FAIL snap cyc=%0d got an=%b code=%0d idx=%0d want an=%b code=%0d idx=%0d",
                        cyc, o_an, o_code, o_digit_idx, sq[i].an, sq[i].code, sq[i].idx);
            end
            if (sq[i].pchk) begin
               total++;
               if (o_frame_tick !== 1'b0 || o_load_ack !== 1'b0) begin
                  bad++;
                  $display("FAIL reset_pulses cyc=%0d got tick=%b ack=%b want 0 0",
                           cyc, o_frame_tick, o_load_ack);
               end
            end
            sq.delete(i);
         end else if (sq[i].cyc < cyc) begin
            total++; bad++;
            $display("FAIL snap_missed cyc=%0d", sq[i].cyc);
            sq.delete(i);
         end
      end
      if (o_frame_tick === 1'b1) begin
         int hit = -1;
         total++;
         foreach (tick_q[i]) if (tick_q[i] == cyc) hit = i;
         if (hit >= 0) tick_q.delete(hit);
         else begin
            bad++;
            $display("FAIL frame_tick unexpected at cyc=%0d want none", cyc);
         end
      end
      if (o_load_ack === 1'b1) begin
         int hit = -1;
         total++;
         foreach (ack_q[i]) if (ack_q[i] == cyc) hit = i;
         if (hit >= 0) ack_q.delete(hit);
         else begin
            bad++;
            $display("FAIL load_ack unexpected at cyc=%0d want none", cyc);
         end
      end
      for (int i = tick_q.size() - 1; i >= 0; i--)
         if (tick_q[i] < cyc) begin
            total++; bad++;
            $display("FAIL frame_tick missing got 0 want 1 at cyc=%0d", tick_q[i]);
            tick_q.delete(i);
         end
      for (int i = ack_q.size() - 1; i >= 0; i--)
         if (ack_q[i] < cyc) begin
            total++; bad++;
            $display("FAIL load_ack missing got 0 want 1 at cyc=%0d", ack_q[i]);
            ack_q.delete(i);
         end
      if (done) begin
         if (sq.size() != 0 || tick_q.size() != 0 || ack_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover got snaps=%0d ticks=%0d acks=%0d want 0",
                     sq.size(), tick_q.size(), ack_q.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_en = 1'b0; i_load = 1'b0; i_codes = '0; i_blank = '0;
      tick_to(2);
      // Reset state, then a load while idle commits immediately with one ack.
      push_snap(2, 4'b1111, 2'd0, 2'd0, 1'b1);
      for (int c = 3; c <= 6; c++) push_snap(c, 4'b1111, 2'd0, 2'd0, 1'b0);
      i_rst = 1'b0; i_load = 1'b1; i_codes = 8'b11_10_01_00; i_blank = 4'b0000;
      ack_q.push_back(4);
      tick_to(3);
      i_load = 1'b0;
      tick_to(6);
      i_en = 1'b1;
      push_frame(7, 8'b11_10_01_00, 4'b0000, 40);
      tick_q.push_back(47); tick_q.push_back(87);
      tick_q.push_back(127); tick_q.push_back(167);
      tick_to(47);
      push_frame(47, 8'b11_10_01_00, 4'b0000, 40);
      // Load during digit 1 show: held back until the frame wrap.
      tick_to(60);
      i_load = 1'b1; i_codes = 8'b00_00_00_11; i_blank = 4'b0000;
      ack_q.push_back(87);
      tick_to(61);
      i_load = 1'b0;
      tick_to(87);
      push_frame(87, 8'b00_00_00_11, 4'b0000, 40);
      tick_to(90);
      i_load = 1'b1; i_codes = 8'b00_01_10_11; i_blank = 4'b0100;
      ack_q.push_back(127);
      tick_to(91);
      i_load = 1'b0;
      tick_to(127);
      push_frame(127, 8'b00_01_10_11, 4'b0100, 40);
      tick_to(167);
      push_frame(167, 8'b00_01_10_11, 4'b0100, 25);
      // Disable mid-show of digit 2, then re-enable from digit 0.
      tick_to(191);
      i_en = 1'b0;
      for (int c = 192; c <= 194; c++) push_snap(c, 4'b1111, 2'd0, 2'd0, 1'b0);
      tick_to(194);
      i_en = 1'b1;
      push_frame(195, 8'b00_01_10_11, 4'b0100, 40);
      tick_q.push_back(235);
      // Reset and load together: load discarded, everything blank afterwards.
      tick_to(240);
      i_rst = 1'b1; i_load = 1'b1; i_codes = 8'hFF; i_blank = 4'b0000; i_en = 1'b0;
      tick_to(241);
      i_rst = 1'b0; i_load = 1'b0;
      push_snap(241, 4'b1111, 2'd0, 2'd0, 1'b1);
      push_snap(242, 4'b1111, 2'd0, 2'd0, 1'b0);
      tick_to(242);
      i_en = 1'b1;
      push_frame(243, 8'h00, 4'b1111, 40);
      tick_q.push_back(283);
      tick_to(290);
      i_en = 1'b0;
      tick_to(292);
      done = 1'b1;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the vending machine display. Feeds one digit code at a time to the shared 2-bit segment decoder and drives the per-digit anode selects. Inserts a guard (all-off) interval between digits to suppress ghosting. Double-buffers new display values so they commit only at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
CODE_W, 2, width of one digit code, matching the segment decoder input
DIGIT_CYCLES, 50000, clocks per digit slot including guard (>= GUARD_CYCLES+1)
GUARD_CYCLES, 500, clocks of all-anodes-off at the start of each slot (>= 1)
AN_ACTIVE_LOW, 1, 1 = anode active level is 0

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_en  in  1  scan enable
i_load  in  1  one-cycle strobe: capture i_codes/i_blank into the staging bank
i_codes  in  NUM_DIGITS*CODE_W  digit k at bits [k*CODE_W +: CODE_W]
i_blank  in  NUM_DIGITS  bit k=1: digit k is never lit
o_code  out  CODE_W  code to the segment decoder input
o_an  out  NUM_DIGITS  anode selects, at most one active
o_digit_idx  out  clog2(NUM_DIGITS)  current slot index
o_frame_tick  out  1  one-cycle pulse on frame wrap
o_load_ack  out  1  one-cycle pulse: staged values now displayed

Behaviour:
- All outputs come straight from registers; no input-to-output combinational path.
- Reset has priority over everything; an i_load in the same cycle is discarded. Reset state:
  - state IDLE, idx 0, cnt 0, pending 0
  - staging and active codes 0; staging and active blank all 1
  - o_an all inactive, o_code 0, o_frame_tick 0, o_load_ack 0
- FSM states: IDLE, GUARD, SHOW.
  - IDLE: o_an inactive, o_code 0. If i_en=1, go to GUARD with idx=0, cnt=0.
  - GUARD: o_an inactive, o_code = active code[idx]. When cnt==GUARD_CYCLES-1, go to SHOW with cnt=0.
  - SHOW: o_an[idx] active unless active blank[idx]=1. When cnt==DIGIT_CYCLES-GUARD_CYCLES-1, go to GUARD with cnt=0 and idx=idx+1, wrapping NUM_DIGITS-1 to 0.
  - On the wrap transition, o_frame_tick pulses in the first GUARD cycle of digit 0.
  - i_en=0 in GUARD or SHOW: next cycle is IDLE with idx 0 and cnt 0; no frame tick.
- Slot timing: each digit occupies exactly DIGIT_CYCLES clocks; one frame is NUM_DIGITS*DIGIT_CYCLES clocks. Blanked digits keep their slot timing.
- Load and commit:
  - i_load copies i_codes/i_blank to the staging bank and sets pending.
  - Commit (staging to active, pending cleared) happens on the frame-wrap edge, or on any edge while in IDLE.
  - o_load_ack pulses for the one cycle after the commit edge.
- Boundary cases:
  - Repeated i_load before commit: staging is overwritten; only one ack is issued.
  - i_load on the commit edge: the commit uses the pre-edge staging contents. The new values land in staging and pending stays 1.
  - Active values never change mid-frame; no tearing.
- Transitions never produce two active anodes, and o_an is never active in GUARD or IDLE.

Decomposition:
- Shared package/header holds:
  - state encoding localparams (IDLE/GUARD/SHOW)
  - anode inactive level derived from AN_ACTIVE_LOW
  - digit-index width function
- Natural sub-module: seg_scan_timer, the slot counter. It has terminal-count outputs for guard end and show end, and a restart input.
- The segment decoder is instantiated by the parent alongside this block, not inside it.

Test Plan:
Use NUM_DIGITS=4, DIGIT_CYCLES=10, GUARD_CYCLES=2, AN_ACTIVE_LOW=1.
1. Assert i_rst for 2 cycles -> o_an=4'b1111, o_code=0, o_digit_idx=0, o_frame_tick=0, o_load_ack=0.
2. i_en=0, i_load with i_codes=8'b11_10_01_00, i_blank=0 -> o_load_ack high exactly 1 cycle. Then i_en=1 -> after 1 cycle o_code=0, 2 cycles o_an=1111, 8 cycles o_an=1110, 2 cycles 1111, 8 cycles 1101 with o_code=1. Thereafter o_frame_tick every 40 cycles.
3. While SHOW digit 1, i_load codes=8'b00_00_00_11 -> o_code/o_an unchanged through digits 2,3. o_load_ack fires 1 cycle after the wrap edge; digit 0 then shows code 3.
4. i_blank=4'b0100 committed -> digit-2 slot keeps o_an=1111 for all 10 cycles, o_code=active code[2]. The frame period stays 40.
5. Drop i_en mid-SHOW of digit 2 -> next cycle o_an=1111, o_digit_idx=0, no frame tick. Re-enable -> restart at digit 0 with a 2-cycle guard.
6. i_rst and i_load in the same cycle, then i_en=1 -> no o_load_ack, all digits blank (o_an=1111 for the full frame).
